light_sequencer: RTL and testbench

Traffic-light phase sequencer that sits directly downstream of the timeout counter `counter10k`. It consumes the counter's sticky `reached` flag, re-arms the counter through `timer_clear`, and advances a Moore state machine through red / red-yellow / green / yellow phases. Each phase lasts a parameterised number of timeout periods. A pedestrian request inserts a walk phase. Outputs drive board LEDs directly.

---
 rtl/light_sequencer_pkg.sv | 32 +++
 rtl/light_sequencer_if.sv | 25 ++
 rtl/light_sequencer_sync_edge.sv | 29 ++
 rtl/light_sequencer.sv | 107 ++++++++++
 tb/tb_light_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/light_sequencer_pkg.sv
// Shared definitions for the traffic-light sequencer.
//   state_t   : phase encoding (3 bits)
//   LAMP_*    : lamp vectors ordered {red, yellow, green, walk}
//   lamps_of  : phase -> lamp vector decode
package light_pkg;

  typedef enum logic [2:0] {
    ST_RED        = 3'd0,
    ST_RED_YELLOW = 3'd1,
    ST_GREEN      = 3'd2,
    ST_YELLOW     = 3'd3,
    ST_WALK       = 3'd4
  } state_t;

  localparam logic [3:0] LAMP_RED    = 4'b1000;
  localparam logic [3:0] LAMP_RY     = 4'b1100;
  localparam logic [3:0] LAMP_GREEN  = 4'b0010;
  localparam logic [3:0] LAMP_YELLOW = 4'b0100;
  localparam logic [3:0] LAMP_WALK   = 4'b1001;

  function automatic logic [3:0] lamps_of(input state_t s);
    case (s)
      ST_RED:        lamps_of = LAMP_RED;
      ST_RED_YELLOW: lamps_of = LAMP_RY;
      ST_GREEN:      lamps_of = LAMP_GREEN;
      ST_YELLOW:     lamps_of = LAMP_YELLOW;
      ST_WALK:       lamps_of = LAMP_WALK;
      default:       lamps_of = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/light_sequencer_if.sv
// Board-side signal bundle of the sequencer.
//   reached     : sticky timeout flag from the timeout counter
//   ped_req     : pedestrian button level (asynchronous)
//   timer_clear : clears/holds the timeout counter while high
//   red/yellow/green/walk : lamp drives
// master = sequencer, slave = counter/board side.
interface light_sequencer_if;
  logic reached;
  logic ped_req;
  logic timer_clear;
  logic red;
  logic yellow;
  logic green;
  logic walk;

  modport master (
    input  reached, ped_req,
    output timer_clear, red, yellow, green, walk
  );

  modport slave (
    output reached, ped_req,
    input  timer_clear, red, yellow, green, walk
  );
endinterface

// File: rtl/light_sequencer_sync_edge.sv
// 2-FF synchroniser followed by a rising-edge detector.
//   tick    : clock
//   reset   : async active-high reset
//   i_async : asynchronous level input
//   o_rise  : one-cycle pulse on a synchronised 0->1 transition
module sync_edge (
  input  logic tick,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);
  logic r_ff1, r_ff2, r_prev;

  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      r_ff1  <= 1'b0;
      r_ff2  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_ff1  <= i_async;
      r_ff2  <= r_ff1;
      r_prev <= r_ff2;
    end
  end

  // Combinational off registered stages: pulse is seen on the third edge
  // after the input rises, which is when the consumer latches it.
  assign o_rise = r_ff2 & ~r_prev;
endmodule

// File: rtl/light_sequencer.sv
// Traffic-light phase sequencer driven by a sticky timeout flag.
//   tick, reset : clock and async active-high reset
//   bus         : light_sequencer_if.master (reached, ped_req in;
//                 timer_clear and lamps out, all registered)
// Each accepted timeout re-arms the counter via a one-cycle timer_clear
// pulse; a 2-cycle guard masks the stale reached while it clears.
module light_sequencer
  import light_pkg::*;
#(
  parameter int unsigned RED_PERIODS    = 4,
  parameter int unsigned RY_PERIODS     = 1,
  parameter int unsigned GREEN_PERIODS  = 4,
  parameter int unsigned YELLOW_PERIODS = 1,
  parameter int unsigned WALK_PERIODS   = 3
) (
  input  logic                  tick,
  input  logic                  reset,
  light_sequencer_if.master     bus
);

  state_t     r_state;
  logic [3:0] r_period_cnt;
  logic [1:0] r_guard;
  logic       r_ped_pending;
  logic       r_init;
  logic       r_tc;
  logic [3:0] r_lamps;

  logic       w_rise;
  logic       w_accept;
  logic       w_last;
  logic       w_ped_evt;
  logic [3:0] w_limit;
  state_t     w_next;

  sync_edge u_ped_sync (
    .tick    (tick),
    .reset   (reset),
    .i_async (bus.ped_req),
    .o_rise  (w_rise)
  );

  function automatic logic [3:0] periods_of(input state_t s);
    case (s)
      ST_RED:        periods_of = 4'(RED_PERIODS);
      ST_RED_YELLOW: periods_of = 4'(RY_PERIODS);
      ST_GREEN:      periods_of = 4'(GREEN_PERIODS);
      ST_YELLOW:     periods_of = 4'(YELLOW_PERIODS);
      ST_WALK:       periods_of = 4'(WALK_PERIODS);
      default:       periods_of = 4'd1;
    endcase
  endfunction

  always_comb begin
    w_accept  = bus.reached & (r_guard == 2'd0);
    w_limit   = periods_of(r_state) - 4'd1;
    w_last    = (r_period_cnt == w_limit);
    // Requests arriving while already walking are dropped.
    w_ped_evt = w_rise & (r_state != ST_WALK);
    w_next    = r_state;
    if (w_accept && w_last) begin
      case (r_state)
        ST_RED:        w_next = ST_RED_YELLOW;
        ST_RED_YELLOW: w_next = ST_GREEN;
        ST_GREEN:      w_next = ST_YELLOW;
        // A request edge in the very cycle YELLOW ends still counts.
        ST_YELLOW:     w_next = (r_ped_pending | w_ped_evt) ? ST_WALK : ST_RED;
        ST_WALK:       w_next = ST_RED_YELLOW;
        default:       w_next = ST_RED;
      endcase
    end
  end

  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RED;
      r_period_cnt  <= 4'd0;
      r_guard       <= 2'd0;
      r_ped_pending <= 1'b0;
      r_init        <= 1'b1;
      r_tc          <= 1'b1;
      r_lamps       <= LAMP_RED;
    end else begin
      // Hold the counter cleared for one extra edge after reset release.
      r_init  <= 1'b0;
      r_tc    <= w_accept | r_init;
      r_state <= w_next;
      r_lamps <= lamps_of(w_next);

      if (w_accept) begin
        r_guard      <= 2'd2;
        r_period_cnt <= w_last ? 4'd0 : r_period_cnt + 4'd1;
      end else if (r_guard != 2'd0) begin
        r_guard <= r_guard - 2'd1;
      end

      if (w_next == ST_WALK && r_state != ST_WALK)
        r_ped_pending <= 1'b0;
      else if (w_ped_evt)
        r_ped_pending <= 1'b1;
    end
  end

  assign bus.timer_clear = r_tc;
  assign {bus.red, bus.yellow, bus.green, bus.walk} = r_lamps;

endmodule

// File: tb/tb_light_sequencer.sv
module tb_light_sequencer;

  localparam logic [3:0] R  = 4'b1000;
  localparam logic [3:0] RY = 4'b1100;
  localparam logic [3:0] G  = 4'b0010;
  localparam logic [3:0] Y  = 4'b0100;
  localparam logic [3:0] W  = 4'b1001;

  logic tick = 1'b0;
  logic reset = 1'b1;

  light_sequencer_if bus();

  light_sequencer dut (
    .tick  (tick),
    .reset (reset),
    .bus   (bus)
  );

  always #5 tick = ~tick;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];
  bit   mon_en    = 1'b0;
  bit   hold_mode = 1'b0;
  bit   have_last = 1'b0;
  bit   prev_tc   = 1'b0;
  int   cyc       = 0;
  int   last_acc  = 0;
  logic [3:0] mon_lamps, mon_exp;

  // Monitor: every timer_clear pulse marks an accepted timeout; the lamps
  // presented in that cycle are checked against the scoreboard.
  always @(negedge tick) begin
    cyc++;
    mon_lamps = {bus.red, bus.yellow, bus.green, bus.walk};
    if (mon_en && bus.timer_clear) begin
      n_tests++;
      if (prev_tc) begin
        n_fail++;
        $display("FAIL tc_width: timer_clear high 2 cycles in a row at cycle %0d, required 1", cyc);
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_accept: lamps %b with empty scoreboard", mon_lamps);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_lamps !== mon_exp) begin
          n_fail++;
          $display("FAIL lamps: got %b required %b (cycle %0d)", mon_lamps, mon_exp, cyc);
        end
      end
      if (hold_mode) begin
        if (have_last) begin
          n_tests++;
          if (cyc - last_acc != 3) begin
            n_fail++;
            $display("FAIL accept_gap: got %0d cycles required 3", cyc - last_acc);
          end
        end
        have_last = 1'b1;
        last_acc  = cyc;
      end
    end
    prev_tc = bus.timer_clear;
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    exp_q.push_back(v);
  endtask

  // Default-parameter cycle up to and including the YELLOW phase.
  task automatic push_to_yellow();
    push(R); push(R); push(R); push(RY);
    push(G); push(G); push(G); push(G); push(Y);
  endtask

  task automatic release_reset();
    @(negedge tick) reset = 1'b0;
    @(negedge tick) chk("init_tc_first_edge", {3'b0, bus.timer_clear}, 4'd1);
    @(negedge tick) chk("init_tc_second_edge", {3'b0, bus.timer_clear}, 4'd0);
    mon_en = 1'b1;
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    bus.reached = 1'b0;
    bus.ped_req = 1'b0;
    exp_q.delete();
    @(negedge tick) reset = 1'b1;
    @(negedge tick);
    chk("rst_lamps", {bus.red, bus.yellow, bus.green, bus.walk}, R);
    chk("rst_tc", {3'b0, bus.timer_clear}, 4'd1);
    release_reset();
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 8 && !bus.timer_clear; i++) @(negedge tick);
    n_tests++;
    if (!bus.timer_clear) begin
      n_fail++;
      $display("FAIL accept_timeout: timer_clear=0 required 1");
    end
    bus.reached = 1'b0;
  endtask

  // One counter period of 12 cycles; optionally presses the button in the gap.
  task automatic do_timeout(input bit ped);
    @(negedge tick) bus.reached = 1'b1;
    wait_accept();
    if (ped) begin
      bus.ped_req = 1'b1;
      repeat (3) @(negedge tick);
      bus.ped_req = 1'b0;
      repeat (7) @(negedge tick);
    end else begin
      repeat (10) @(negedge tick);
    end
  endtask

  // Button rises so its synchronised edge lands on the same edge as reached.
  task automatic sim_timeout();
    @(negedge tick) bus.ped_req = 1'b1;
    @(negedge tick);
    @(negedge tick) bus.reached = 1'b1;
    wait_accept();
    repeat (3) @(negedge tick);
    bus.ped_req = 1'b0;
    repeat (8) @(negedge tick);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge tick);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected accepts never seen, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    bus.reached = 1'b0;
    bus.ped_req = 1'b0;

    // Normal cycle, reached every 12 cycles.
    apply_reset();
    push_to_yellow(); push(R);
    for (int k = 0; k < 10; k++) do_timeout(1'b0);
    wait_drain("normal_cycle", 50);

    // reached stuck high: guard limits accepts to one every 3 cycles.
    apply_reset();
    push_to_yellow(); push(R);
    hold_mode = 1'b1;
    have_last = 1'b0;
    @(negedge tick) bus.reached = 1'b1;
    wait_drain("hold_high", 200);
    bus.reached = 1'b0;
    hold_mode = 1'b0;
    repeat (5) @(negedge tick);

    // Press during GREEN -> WALK; press during WALK is ignored.
    apply_reset();
    push_to_yellow(); push(W); push(W); push(W); push(RY);
    push(G); push(G); push(G); push(G); push(Y); push(R);
    for (int k = 1; k <= 19; k++) do_timeout(k == 6 || k == 11);
    wait_drain("ped_path", 50);

    // Button edge coincides with the timeout that ends YELLOW.
    apply_reset();
    push_to_yellow(); push(W); push(W); push(W); push(RY);
    for (int k = 0; k < 9; k++) do_timeout(1'b0);
    sim_timeout();
    for (int k = 0; k < 3; k++) do_timeout(1'b0);
    wait_drain("ped_simultaneous", 50);

    // Async reset mid-GREEN (period_cnt=2), then a full RED phase.
    apply_reset();
    push(R); push(R); push(R); push(RY); push(G); push(G); push(G);
    for (int k = 0; k < 7; k++) do_timeout(1'b0);
    wait_drain("pre_mid_reset", 50);
    mon_en = 1'b0;
    @(negedge tick);
    #2 reset = 1'b1;
    #1;
    chk("midrst_lamps", {bus.red, bus.yellow, bus.green, bus.walk}, R);
    chk("midrst_tc", {3'b0, bus.timer_clear}, 4'd1);
    @(negedge tick);
    release_reset();
    push(R); push(R); push(R); push(RY);
    for (int k = 0; k < 4; k++) do_timeout(1'b0);
    wait_drain("post_mid_reset", 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
